led_mode_controller: RTL
========================

LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive clocks a synchronized switch level must differ from its stable value before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter TICK_LIMIT, default 6250000, meaning the clocks per pattern step in slow speed (0.25 s at 25 MHz).
REQ-003 SHALL have port i_Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports i_Switch_1..i_Switch_4, input, 1 bit each: raw asynchronous pushbuttons, 1 = pressed.
REQ-006 SHALL have ports o_LED_1..o_LED_4, output, 1 bit each: registered LED drives, 1 = lit.
REQ-007 SHALL have port o_Mode, output, 2 bits: current mode, with OFF=0, STATIC=1, BLINK=2, CHASE=3.

Function
REQ-008 SHALL pass each i_Switch_n through a two-flop synchronizer before any other use.
REQ-009 SHALL keep a per-switch stable level and counter: counter increments while the synchronized level differs from the stable level, clears when it matches, and the stable level takes the synchronized value on the cycle the counter reaches DEBOUNCE_LIMIT-1.
REQ-010 SHALL generate a one-cycle press event per switch on the cycle after the stable level goes 1->0 (release); no event on press and no repeat while held.
REQ-011 SHALL, on a Switch_1 event, advance the mode OFF->STATIC->BLINK->CHASE->OFF.
REQ-012 SHALL, on a Switch_2 event, force the mode to OFF from any mode.
REQ-013 SHALL, when Switch_1 and Switch_2 events coincide, give Switch_2 priority: the result is OFF.
REQ-014 SHALL, on a Switch_3 event, toggle the speed flag (0 = slow, 1 = fast).
REQ-015 SHALL, on a Switch_4 event, toggle the pause flag.
REQ-016 SHALL keep the speed and pause flags across mode changes; only reset clears them.
REQ-017 SHALL run a tick counter with period TICK_LIMIT clocks when slow and TICK_LIMIT/2 clocks when fast (integer division, minimum 1), emitting a one-cycle tick on its terminal count.
REQ-018 SHALL hold the tick counter and suppress ticks while paused or in OFF or STATIC.
REQ-019 SHALL clear the tick counter on every mode change.
REQ-020 SHALL, on a speed toggle, clear the tick counter if its value is at or above the new terminal count; otherwise it continues counting.
REQ-021 SHALL drive LEDs as follows: OFF = 0000; STATIC = 1111; BLINK = all four equal, starting lit on mode entry and inverting on each tick; CHASE = one-hot, starting on LED_1 on mode entry and rotating LED_1->2->3->4->1 on each tick.
REQ-022 SHALL update o_Mode and the LED pattern registers on the clock edge at which the event is sampled, so they are visible one cycle after the event pulse.
REQ-023 SHALL ignore events from all switches during reset and for the synchronizer and debounce settling after reset; stable levels reset to 0, so a switch held through reset produces no event until it is released after debouncing.

Reset
REQ-024 SHALL, while i_Rst=1, immediately force: o_Mode=0, all o_LED=0, speed=0, pause=0, tick counter=0, all debounce counters, synchronizers and stable levels=0.
REQ-025 SHALL, if reset is asserted mid-pattern or mid-debounce, discard all in-progress state, and after reset release SHALL behave identically to power-up.

Verification (DEBOUNCE_LIMIT=4, TICK_LIMIT=8)
REQ-026 SHALL cover: Switch_1 pressed 10 cycles then released -> exactly one event after release; o_Mode 0->1; LEDs 1111.
REQ-027 SHALL cover: Switch_1 glitch of 2 cycles -> no event; o_Mode unchanged.
REQ-028 SHALL cover: three Switch_1 presses, then 24 cycles -> o_Mode=3; LEDs 0001, 0010, 0100, 1000 at 8-cycle steps.
REQ-029 SHALL cover: in BLINK, Switch_3 event -> toggle period becomes 4 cycles; Switch_4 event -> LEDs frozen for 20 cycles; second Switch_4 event -> toggling resumes.
REQ-030 SHALL cover: Switch_1 and Switch_2 release events in the same cycle while in CHASE -> o_Mode=0; LEDs 0000.
REQ-031 SHALL cover: i_Rst asserted asynchronously mid-CHASE with Switch_1 held -> outputs 0 without a clock edge; no event until Switch_1 is released and debounced.

Source files
------------

// File: rtl/led_mode_controller.sv
// led_mode_controller: four debounced pushbuttons select and tune an LED pattern.
// Buttons act on release; BLINK/CHASE step on a tick whose rate and pause are user-toggled.
//
// state       | meaning
// MODE_OFF    | all LEDs dark, tick counter held
// MODE_STATIC | all LEDs lit, tick counter held
// MODE_BLINK  | all four LEDs invert together on each tick
// MODE_CHASE  | single lit LED rotates 1->2->3->4->1 on each tick
module led_mode_controller #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int TICK_LIMIT     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode
);
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    localparam int DB_LIMIT    = (DEBOUNCE_LIMIT < 1) ? 1 : DEBOUNCE_LIMIT;
    localparam int DB_W        = $clog2(DB_LIMIT + 1);
    localparam int SLOW_PERIOD = (TICK_LIMIT < 1) ? 1 : TICK_LIMIT;
    localparam int FAST_PERIOD = ((TICK_LIMIT / 2) < 1) ? 1 : (TICK_LIMIT / 2);
    localparam int TK_W        = $clog2(SLOW_PERIOD + 1);

    localparam logic [DB_W-1:0] DB_TC   = DB_W'(DB_LIMIT - 1);
    localparam logic [TK_W-1:0] SLOW_TC = TK_W'(SLOW_PERIOD - 1);
    localparam logic [TK_W-1:0] FAST_TC = TK_W'(FAST_PERIOD - 1);

    logic [3:0] sw_raw, sw_meta, sw_sync, sw_stable, sw_stable_d, sw_evt;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            sw_stable_d <= '0;
        end else begin
            sw_meta     <= sw_raw;
            sw_sync     <= sw_meta;
            sw_stable_d <= sw_stable;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_debounce
            logic [DB_W-1:0] db_cnt;
            logic            stable;

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    db_cnt <= '0;
                    stable <= 1'b0;
                end else if (sw_sync[g] != stable) begin
                    if (db_cnt == DB_TC) begin
                        stable <= sw_sync[g];
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end

            assign sw_stable[g] = stable;
        end
    endgenerate

    // Release of a debounced button is the user action.
    assign sw_evt = sw_stable_d & ~sw_stable;

    mode_t           mode, mode_next;
    logic            mode_evt, speed, pause, running, tick;
    logic [TK_W-1:0] tick_cnt, tick_tc, tick_tc_toggled;
    logic [3:0]      led, led_next;

    assign mode_evt        = sw_evt[0] | sw_evt[1];
    assign tick_tc         = speed ? FAST_TC : SLOW_TC;
    assign tick_tc_toggled = speed ? SLOW_TC : FAST_TC;
    assign running         = ((mode == MODE_BLINK) || (mode == MODE_CHASE)) && !pause;
    assign tick            = running && (tick_cnt == tick_tc);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            speed    <= 1'b0;
            pause    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            speed <= speed ^ sw_evt[2];
            pause <= pause ^ sw_evt[3];
            // A speed change must not strand the count beyond the new terminal value.
            if (mode_evt || tick) begin
                tick_cnt <= '0;
            end else if (sw_evt[2] && (tick_cnt >= tick_tc_toggled)) begin
                tick_cnt <= '0;
            end else if (running) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            mode <= MODE_OFF;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next = mode;
        if (sw_evt[1]) begin
            mode_next = MODE_OFF;
        end else if (sw_evt[0]) begin
            mode_next = mode_t'(mode + 2'd1);
        end
    end

    always_comb begin
        led_next = led;
        if (mode_evt) begin
            case (mode_next)
                MODE_OFF:    led_next = 4'b0000;
                MODE_STATIC: led_next = 4'b1111;
                MODE_BLINK:  led_next = 4'b1111;
                MODE_CHASE:  led_next = 4'b0001;
                default:     led_next = 4'b0000;
            endcase
        end else if (tick) begin
            if (mode == MODE_BLINK) begin
                led_next = ~led;
            end else begin
                led_next = {led[2:0], led[3]};
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            led <= 4'b0000;
        end else begin
            led <= led_next;
        end
    end

    assign o_LED_1 = led[0];
    assign o_LED_2 = led[1];
    assign o_LED_3 = led[2];
    assign o_LED_4 = led[3];
    assign o_Mode  = mode;

endmodule
